// File: rtl/maxnet_sum_ctrl.sv
// Reduces N streamed float32 operands into one sum through a shared external zero-latency Adder.
// One operand per cycle in ACC (in_ready held high); sum_valid rises the cycle after the N-th beat and holds until sum_ack.
module maxnet_sum_ctrl #(
    parameter int N     = 4,
    parameter int CNT_W = $clog2(N)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_neg,
    output logic        in_ready,
    output logic [31:0] adder_a,
    output logic [31:0] adder_b,
    input  logic [31:0] adder_out,
    input  logic        adder_ovf,
    output logic [31:0] sum,
    output logic        sum_valid,
    input  logic        sum_ack,
    output logic        overflow,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t            state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              sum_valid_q, sum_valid_d;

    logic [31:0]       opb;
    logic              beat;

    assign opb  = {in_data[31] ^ in_neg, in_data[30:0]};
    assign beat = in_valid & in_ready_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACC;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACC: begin
                if (beat) begin
                    // The first operand loads directly; the Adder's view of the stale acc is meaningless then.
                    if (cnt_q == '0) begin
                        acc_d = opb;
                    end else begin
                        acc_d = adder_out;
                        ovf_d = ovf_q | adder_ovf;
                    end
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (sum_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == ACC);
        busy_d      = (state_d != IDLE);
        sum_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= 32'h0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign adder_a   = acc_q;
    assign adder_b   = opb;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign sum_valid = sum_valid_q;
    assign sum       = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/maxnet_sum_ctrl.md
Name: maxnet_sum_ctrl

Overview:
- Sequences one shared combinational float32 Adder to reduce N streamed float32 operands into a single sum.
- Feeds the Maxnet inhibition stage, which needs the sum of neuron activations (optionally sign-flipped per operand).
- Owns the accumulator register, element counter, sticky overflow and result handshake. The Adder instance sits outside this block and connects through the adder_* ports.

Parameters:
N, 4, number of operands per reduction (N >= 2)
CNT_W, $clog2(N), element-counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin reduction; accepted only in IDLE
in_valid  input  1  operand valid
in_data  input  32  operand, IEEE-754 single
in_neg  input  1  operand is negated (sign bit inverted) before use
in_ready  output  1  block accepts operand this cycle
adder_a  output  32  Adder operand a (accumulator)
adder_b  output  32  Adder operand b (conditioned operand)
adder_out  input  32  Adder result
adder_ovf  input  1  Adder overflow flag
sum  output  32  reduction result
sum_valid  output  1  result valid, held until sum_ack
sum_ack  input  1  consumer takes result
overflow  output  1  sticky overflow for current/last reduction
busy  output  1  high in ACC or DONE

Behaviour:
- Reset (async, any state): state=IDLE, acc=32'h0, cnt=0, sum_valid=0, overflow=0, in_ready=0, busy=0. Reset mid-reduction discards partial sum; no sum_valid produced.
- States:
  - IDLE: in_ready=0, busy=0. start=1 -> ACC; same edge: cnt=0, overflow=0.
  - ACC: in_ready=1, busy=1. Beat = in_valid & in_ready.
  - DONE: in_ready=0, busy=1, sum_valid=1. sum_ack=1 -> IDLE, sum_valid=0 next cycle.
- start is ignored outside IDLE. sum_ack is ignored outside DONE.
- Operand conditioning: opb = {in_data[31]^in_neg, in_data[30:0]}.
- Adder drive (combinational): adder_a=acc and adder_b=opb, continuously. The Adder has zero latency, so one beat is consumed per cycle.
- Accumulation on a beat:
  - cnt==0: acc<=opb. This first load bypasses the Adder, and adder_ovf is ignored.
  - cnt>0: acc<=adder_out; overflow<=overflow|adder_ovf.
  - cnt<=cnt+1.
  - Beat with cnt==N-1: cnt wraps to 0 and state -> DONE next cycle.
- No beat in ACC (in_valid=0): all state holds; no timeout.
- sum=acc (registered). It is stable throughout DONE and keeps its value in IDLE until the next reduction's first beat.
- Latency: sum_valid rises the cycle after the N-th beat. The minimum start-to-sum_valid time is N+1 cycles with back-to-back beats.
- overflow stays valid in DONE and holds in IDLE. It is cleared only by an accepted start (or reset).
- start and sum_ack asserted together in DONE: sum_ack is taken and start is ignored. A new start is needed in IDLE.
- Arithmetic (rounding, infinity, cancellation to zero) is entirely the Adder's. This block never alters adder_out.

Test Plan:
- Back-to-back sum: start, then beats 3F800000, 40000000, 40400000, 40800000 (1,2,3,4), in_neg=0, N=4 -> sum_valid the cycle after beat 4, sum=41200000 (10.0), overflow=0; sum_ack -> IDLE next cycle.
- Negation and bubbles: beats 40800000(neg=0), in_valid=0 for 2 cycles, 3F800000(neg=1), 40000000(neg=1), 3F800000(neg=0) -> sum=40000000 (2.0); in_ready high throughout ACC; counter does not advance on bubbles.
- Overflow sticky: first beat 7F800000 (+inf), then three beats of 3F800000 -> overflow=1 in DONE and still 1 in IDLE. After the next start and four finite beats, overflow=0.
- First-beat bypass: single-reduction beat 0 = 7F800000 with adder_ovf forced 1 during beat 0 -> overflow remains 0 after beat 0 (ignored), acc=7F800000.
- Reset mid-operation: assert rst after 2 of 4 beats -> in the same cycle (async) in_ready=0, busy=0, sum_valid=0, acc=0. After release, a full 4-beat reduction of 1.0 values gives sum=40800000 (4.0).
- Handshake corners: start pulses during ACC and DONE are ignored (cnt unchanged). Hold sum_ack low for 5 cycles -> sum and sum_valid stable. start+sum_ack together in DONE -> IDLE, no new reduction begins.
